fc_argmax: RTL
==============

Name: fc_argmax

Overview:
- Classifier output stage, directly downstream of the fully connected layer.
- Consumes the stream of NUM_CLASSES signed class scores, one per valid cycle, that the FC layer emits for each image.
- Tracks the running maximum and its index, then emits the winning class index as a one-cycle-valid decision.
- Also keeps a count of completed images for the test harness.

Parameters:
- NUM_CLASSES, 10, scores per image; class index runs 0..NUM_CLASSES-1.
- DATA_WIDTH, 12, width of each signed two's-complement score.
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.
- FRAME_CNT_WIDTH, 16, width of the completed-image counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  score on data_in is valid this cycle.
- data_in  in  DATA_WIDTH  signed class score; scores arrive in class order 0,1,...,NUM_CLASSES-1.
- decision  out  IDX_WIDTH  winning class index; valid only while valid_out=1.
- valid_out  out  1  one-cycle pulse, decision valid.
- busy  out  1  high while an image is partially received (sample count 1..NUM_CLASSES-1).
- frame_cnt  out  FRAME_CNT_WIDTH  number of decisions issued since reset; wraps modulo 2^FRAME_CNT_WIDTH.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears all of: decision, valid_out, busy, frame_cnt, sample counter, running max, max index. Reset has priority over valid_in in the same cycle.
- State machine:
  - IDLE: sample counter = 0.
  - ACCUM: sample counter 1..NUM_CLASSES-1.
  - Transition back to IDLE happens in the same edge that registers the decision.
  - busy = (state == ACCUM), registered.
- Sample counter advances only on cycles with valid_in=1. Gaps of any length between samples are allowed and leave state unchanged.
- First sample of an image (counter = 0): load running max = data_in and max index = 0 unconditionally. No comparison against stale state.
- Later samples k (1..NUM_CLASSES-1):
  - Compare with a signed comparison, the full DATA_WIDTH with no truncation.
  - If data_in > running max (strictly), replace the max and set index = k.
  - On a tie the lower index wins.
- Final sample (k = NUM_CLASSES-1), same edge:
  - decision <= the winner including this sample, using the combinational compare.
  - valid_out <= 1, frame_cnt <= frame_cnt+1, counter <= 0.
  - Latency: valid_out is high in the cycle right after the edge that accepted the last score.
- valid_out is high for exactly one cycle. decision holds its value until the next decision or reset.
- Back-to-back images: a valid_in in the cycle valid_out is high is accepted as class 0 of the next image. There are no bubbles and no backpressure. The block accepts one sample per cycle forever.
- Reset mid-image discards the partial image. No valid_out is issued for it.
- frame_cnt wraps from all-ones to 0 silently.
- Extreme values: most-negative (0x800) and most-positive (0x7FF) scores compare correctly.
- X on data_in while valid_in=0 must not corrupt state.

Optional Feature:
- Macro: ARGMAX_SCORE_OUT_EN.
- Defined: adds output port max_score, DATA_WIDTH, signed.
  - Registered on the same edge as decision and holds the winning score.
  - Reset value 0; holds between decisions.
- Undefined: the port and its register are absent. The other ports and timing are identical.

Test Plan:
- Basic argmax: reset, then scores 5,-3,100,7,0,99,-2048,1,2,3 on consecutive cycles -> one cycle after the 10th score, valid_out=1 and decision=2 (max_score=100 if enabled); frame_cnt=1.
- Negative-only and ties: all ten scores = -50 -> decision=0. Then scores -100 x9 with class 7 = -1 -> decision=7.
- Gapped input: same vector as the basic case with 0-3 idle cycles randomly between samples -> decision=2, single valid_out pulse; busy=1 from after the first sample until the decision edge.
- Back-to-back images: two 10-score images with no gap (winners 9 and 0, second image's class 0 = 0x7FF) -> valid_out pulses exactly 10 cycles apart, decisions 9 then 0, frame_cnt=2.
- Reset mid-image: after 6 scores assert rst_n=0 for one cycle, then send a full image with winner 4 -> no pulse for the partial image; one pulse with decision=4; frame_cnt=1.
- Counter wrap: with FRAME_CNT_WIDTH=2, send 5 images -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fc_argmax.sv
// Argmax stage behind the FC layer. It picks the highest signed class score in each image and counts the decisions issued.
// The ARGMAX_SCORE_OUT_EN build define adds a max_score output that holds the winning score.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for class 0 of an image (sample count 0)
// ST_ACCUM | image partially received (sample count 1..N-1)
module fc_argmax #(
    parameter int NUM_CLASSES     = 10,
    parameter int DATA_WIDTH      = 12,
    parameter int IDX_WIDTH       = 4,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [IDX_WIDTH-1:0]         decision,
    output logic                         valid_out,
    output logic                         busy,
    output logic [FRAME_CNT_WIDTH-1:0]   frame_cnt
`ifdef ARGMAX_SCORE_OUT_EN
    ,
    output logic signed [DATA_WIDTH-1:0] max_score
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    logic [0:0]                    state;
    logic [IDX_WIDTH-1:0]          sample_cnt;
    logic signed [DATA_WIDTH-1:0]  run_max;
    logic [IDX_WIDTH-1:0]          max_idx;

    logic signed [DATA_WIDTH-1:0]  score;
    logic                          is_first;
    logic                          is_last;
    logic                          take_new;
    logic signed [DATA_WIDTH-1:0]  next_max;
    logic [IDX_WIDTH-1:0]          next_idx;

    // Class 0 always loads so a stale max from the previous image can never win.
    // A strict greater-than keeps the lower index on ties.
    always_comb begin
        score    = $signed(data_in);
        is_first = (sample_cnt == '0);
        is_last  = (sample_cnt == LAST_IDX);
        take_new = is_first || (score > run_max);
        next_max = take_new ? score : run_max;
        next_idx = take_new ? sample_cnt : max_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            run_max    <= '0;
            max_idx    <= '0;
            decision   <= '0;
            valid_out  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                run_max <= next_max;
                max_idx <= next_idx;
                if (is_last) begin
                    decision   <= next_idx;
                    valid_out  <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                    sample_cnt <= '0;
                    state      <= ST_IDLE;
                end else begin
                    sample_cnt <= sample_cnt + 1'b1;
                    state      <= ST_ACCUM;
                end
            end
        end
    end

    assign busy = (state == ST_ACCUM);

`ifdef ARGMAX_SCORE_OUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_score <= '0;
        end else if (valid_in && is_last) begin
            max_score <= next_max;
        end
    end
`endif

endmodule
